grid_controller: RTL

Upstream game-state owner for the 3x3 tic-tac-toe datapath. It turns pre-debounced single-cycle button pulses into cursor moves and mark placements, and maintains the 18-bit `grid_state` that feeds the win checker. It also alternates turns, waits for the registered `is_win` verdict after each placement, and latches the win/draw outcome for the display stage.

---
 rtl/grid_pkg.sv | 30 +++
 rtl/grid_controller_if.sv | 43 ++++
 rtl/cursor_nav.sv | 59 +++++
 rtl/grid_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: cell encodings, FSM states and the cell-to-slice helper
// shared by the grid controller, win checker and display stage.
package grid_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] GS_PLAY = 2'b00;
    localparam logic [1:0] GS_BUSY = 2'b01;
    localparam logic [1:0] GS_WIN  = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;

    localparam logic [3:0] CURSOR_HOME = 4'd4;
    localparam logic [3:0] MOVES_FULL  = 4'd9;

    typedef enum logic [2:0] {
        ST_PLAY,
        ST_WAIT,
        ST_EVAL,
        ST_WIN,
        ST_DRAW
    } fsm_t;

    // Low bit of cell k; cell 0 (top-left) sits in the top bits.
    function automatic logic [4:0] cell_lsb(input logic [3:0] k);
        return 5'd16 - {k, 1'b0};
    endfunction

endpackage

// File: rtl/grid_controller_if.sv
// grid_controller_if: button pulses, checker verdict and game outputs.
// btn_undo exists only when GRID_UNDO_EN is defined.
interface grid_controller_if;

`ifdef GRID_UNDO_EN
    logic        btn_undo;
`endif
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_place;
    logic        new_game;
    logic        is_win;
    logic [17:0] grid_state;
    logic [3:0]  cursor;
    logic        turn;
    logic [1:0]  game_state;
    logic [1:0]  winner;
    logic [3:0]  move_count;
    logic        illegal;

    modport slave (
`ifdef GRID_UNDO_EN
        input  btn_undo,
`endif
        input  btn_up, btn_down, btn_left, btn_right,
        input  btn_place, new_game, is_win,
        output grid_state, cursor, turn, game_state,
        output winner, move_count, illegal
    );

    modport master (
`ifdef GRID_UNDO_EN
        output btn_undo,
`endif
        output btn_up, btn_down, btn_left, btn_right,
        output btn_place, new_game, is_win,
        input  grid_state, cursor, turn, game_state,
        input  winner, move_count, illegal
    );

endinterface

// File: rtl/cursor_nav.sv
// cursor_nav: cursor register with row/column wrap and
// up > down > left > right priority among direction pulses.
module cursor_nav
    import grid_pkg::*;
(
    input  logic       clk,
    input  logic       reset_flag,
    input  logic       clear,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       load,
    input  logic [3:0] load_cell,
    output logic [3:0] cursor
);

    logic       left_edge;
    logic       right_edge;
    logic [3:0] cursor_nxt;

    assign left_edge  = (cursor == 4'd0) || (cursor == 4'd3) ||
                        (cursor == 4'd6);
    assign right_edge = (cursor == 4'd2) || (cursor == 4'd5) ||
                        (cursor == 4'd8);

    always_comb begin
        cursor_nxt = cursor;
        if (clear) begin
            cursor_nxt = CURSOR_HOME;
        end else if (load) begin
            cursor_nxt = load_cell;
        end else if (enable) begin
            if (btn_up) begin
                cursor_nxt = (cursor < 4'd3) ? cursor + 4'd6
                                             : cursor - 4'd3;
            end else if (btn_down) begin
                cursor_nxt = (cursor > 4'd5) ? cursor - 4'd6
                                             : cursor + 4'd3;
            end else if (btn_left) begin
                cursor_nxt = left_edge ? cursor + 4'd2
                                       : cursor - 4'd1;
            end else if (btn_right) begin
                cursor_nxt = right_edge ? cursor - 4'd2
                                        : cursor + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            cursor <= CURSOR_HOME;
        end else begin
            cursor <= cursor_nxt;
        end
    end

endmodule

// File: rtl/grid_controller.sv
// grid_controller: tic-tac-toe game-state owner (cursor, marks, turns).
// Define GRID_UNDO_EN to add a one-level undo of the last placement.
module grid_controller
    import grid_pkg::*;
(
    input  logic               clk,
    input  logic               reset_flag,
    grid_controller_if.slave   bus
);

    fsm_t        state;
    fsm_t        state_nxt;
    logic [17:0] grid;
    logic        turn;
    logic [1:0]  winner;
    logic [3:0]  moves;
    logic        illegal_q;
    logic [3:0]  cursor;
    logic [1:0]  mark;
    logic [1:0]  cur_cell;
    logic        btn_undo;
    logic        undo_ok;
    logic [3:0]  undo_cell;
    logic        do_place;
    logic        do_illegal;
    logic        do_toggle;
    logic        do_win;
    logic        do_undo;
    logic        nav_en;

    assign mark     = turn ? CELL_O : CELL_X;
    assign cur_cell = grid[cell_lsb(cursor) +: 2];

`ifdef GRID_UNDO_EN
    assign btn_undo = bus.btn_undo;

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            undo_ok   <= 1'b0;
            undo_cell <= 4'd0;
        end else if (bus.new_game) begin
            undo_ok   <= 1'b0;
            undo_cell <= 4'd0;
        end else if (do_place) begin
            undo_ok   <= 1'b1;
            undo_cell <= cursor;
        end else if (do_undo) begin
            undo_ok   <= 1'b0;
        end
    end
`else
    assign btn_undo  = 1'b0;
    assign undo_ok   = 1'b0;
    assign undo_cell = 4'd0;
`endif

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            state <= ST_PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    // A place or undo pulse consumes the cycle; directions only otherwise.
    always_comb begin
        state_nxt  = state;
        do_place   = 1'b0;
        do_illegal = 1'b0;
        do_toggle  = 1'b0;
        do_win     = 1'b0;
        do_undo    = 1'b0;
        nav_en     = 1'b0;
        if (bus.new_game) begin
            state_nxt = ST_PLAY;
        end else begin
            unique case (state)
                ST_PLAY: begin
                    if (bus.btn_place) begin
                        if (cur_cell == CELL_EMPTY) begin
                            do_place  = 1'b1;
                            state_nxt = ST_WAIT;
                        end else begin
                            do_illegal = 1'b1;
                        end
                    end else if (btn_undo) begin
                        do_undo = undo_ok;
                    end else begin
                        nav_en = 1'b1;
                    end
                end
                ST_WAIT: state_nxt = ST_EVAL;
                ST_EVAL: begin
                    if (bus.is_win) begin
                        do_win    = 1'b1;
                        state_nxt = ST_WIN;
                    end else if (moves == MOVES_FULL) begin
                        state_nxt = ST_DRAW;
                    end else begin
                        do_toggle = 1'b1;
                        state_nxt = ST_PLAY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            grid      <= '0;
            turn      <= 1'b0;
            winner    <= CELL_EMPTY;
            moves     <= 4'd0;
            illegal_q <= 1'b0;
        end else if (bus.new_game) begin
            grid      <= '0;
            turn      <= 1'b0;
            winner    <= CELL_EMPTY;
            moves     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= do_illegal;
            if (do_place) begin
                grid[cell_lsb(cursor) +: 2] <= mark;
                moves <= moves + 4'd1;
            end
            if (do_undo) begin
                grid[cell_lsb(undo_cell) +: 2] <= CELL_EMPTY;
                moves <= moves - 4'd1;
            end
            if (do_toggle || do_undo) begin
                turn <= ~turn;
            end
            if (do_win) begin
                winner <= mark;
            end
        end
    end

    cursor_nav u_cursor_nav (
        .clk        (clk),
        .reset_flag (reset_flag),
        .clear      (bus.new_game),
        .enable     (nav_en),
        .btn_up     (bus.btn_up),
        .btn_down   (bus.btn_down),
        .btn_left   (bus.btn_left),
        .btn_right  (bus.btn_right),
        .load       (do_undo),
        .load_cell  (undo_cell),
        .cursor     (cursor)
    );

    always_comb begin
        unique case (state)
            ST_PLAY: bus.game_state = GS_PLAY;
            ST_WIN:  bus.game_state = GS_WIN;
            ST_DRAW: bus.game_state = GS_DRAW;
            default: bus.game_state = GS_BUSY;
        endcase
    end

    assign bus.grid_state = grid;
    assign bus.cursor     = cursor;
    assign bus.turn       = turn;
    assign bus.winner     = winner;
    assign bus.move_count = moves;
    assign bus.illegal    = illegal_q;

endmodule
